paint_cursor: RTL and testbench

- Keyboard-driven cursor/brush position generator for the paint datapath. Replaces the fixed-step bouncing mover.
- Updates once per frame_clk. Position is clamped to the screen, not bounced.
- Step size accelerates while a direction key is held. Brush size is adjustable, and the pen state is toggled from the keyboard.
- Feeds the colour mapper and the frame-buffer write logic.

---
 rtl/paint_cursor_if.sv | 42 ++++
 rtl/paint_cursor.sv | 206 ++++++++++++++++++++
 tb/tb_paint_cursor.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/paint_cursor_if.sv
// paint_cursor_if
// ---------------
// Bundles the keyboard input and the cursor outputs of the paint cursor so the
// keyboard front end, the cursor and its consumers share one connection.
//
// Signals:
//   keycode  8  USB HID keycode from the keyboard side (0x00 = no key)
//   CursorX  10 cursor centre column
//   CursorY  10 cursor centre row
//   CursorS  10 brush half-size
//   Moving   1  high while the cursor is being steered by a direction key
//   PenDown  1  pen state, high while painting
//
// Modports:
//   master  keyboard side: drives keycode, observes the cursor
//   slave   cursor side: consumes keycode, drives the cursor outputs
interface paint_cursor_if;
    logic [7:0] keycode;
    logic [9:0] CursorX;
    logic [9:0] CursorY;
    logic [9:0] CursorS;
    logic       Moving;
    logic       PenDown;

    modport master (
        output keycode,
        input  CursorX,
        input  CursorY,
        input  CursorS,
        input  Moving,
        input  PenDown
    );

    modport slave (
        input  keycode,
        output CursorX,
        output CursorY,
        output CursorS,
        output Moving,
        output PenDown
    );
endinterface

// File: rtl/paint_cursor.sv
// paint_cursor
// ------------
// Keyboard-driven cursor/brush position generator for the paint datapath.
// Once per frame_clk edge the cursor moves by an accelerating step while a
// direction key is held, staying inside the screen inset by the brush
// half-size. '=' and '-' grow/shrink the brush, space toggles the pen.
//
// Ports:
//   Reset      in  asynchronous active-high reset
//   frame_clk  in  one rising edge per video frame
//   cursorBus  paint_cursor_if.slave (keycode in; CursorX/Y/S, Moving,
//              PenDown out, all registered)
//
// Build option:
//   CURSOR_WRAP_EN  when defined, a move that crosses a screen limit wraps to
//                   the opposite limit instead of saturating. Size changes
//                   always clamp.
module paint_cursor #(
    parameter int X_MAX        = 639,
    parameter int Y_MAX        = 479,
    parameter int X_CENTER     = 320,
    parameter int Y_CENTER     = 240,
    parameter int SIZE_INIT    = 4,
    parameter int SIZE_MIN     = 1,
    parameter int SIZE_MAX     = 16,
    parameter int STEP         = 1,
    parameter int STEP_MAX     = 8,
    parameter int ACCEL_FRAMES = 8
) (
    input  logic          Reset,
    input  logic          frame_clk,
    paint_cursor_if.slave cursorBus
);

    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_PLUS  = 8'h2E;
    localparam logic [7:0] KEY_MINUS = 8'h2D;

    // Hold count at which the step has reached STEP_MAX; counting further
    // would change nothing.
    localparam int HOLD_MAX = (STEP_MAX - STEP) * ACCEL_FRAMES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 2);

    localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
    localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);

    typedef enum logic {
        IDLE,
        MOVE
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          prevKey_q;
    logic [HOLD_W-1:0]   holdCnt_q, holdCnt_d;
    logic [9:0]          cursorX_q, cursorX_d;
    logic [9:0]          cursorY_q, cursorY_d;
    logic [9:0]          cursorS_q, cursorS_d;
    logic                penDown_q, penDown_d;

    logic                isDir;
    logic                sizeUp;
    logic                sizeDown;
    int                  stepInt;
    logic signed [10:0]  step;
    logic signed [10:0]  dx, dy;
    logic signed [10:0]  posX, posY;
    logic signed [10:0]  sizeCur, sizeNew;
    logic signed [10:0]  nextX, nextY;

    // Saturate v into [lo, hi].
    function automatic logic signed [10:0] clampPos(input logic signed [10:0] v,
                                                    input logic signed [10:0] lo,
                                                    input logic signed [10:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    // Bound a freshly moved coordinate: wrap to the opposite limit when the
    // wrap option is built in, otherwise saturate like a size re-clamp.
    function automatic logic signed [10:0] limitMove(input logic signed [10:0] v,
                                                     input logic signed [10:0] lo,
                                                     input logic signed [10:0] hi);
`ifdef CURSOR_WRAP_EN
        if (v < lo)
            return hi;
        else if (v > hi)
            return lo;
        else
            return v;
`else
        return clampPos(v, lo, hi);
`endif
    endfunction

    // State register. Reset is asynchronous so it wins immediately, even in
    // the middle of a press, and wipes the hold history with prevKey.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            prevKey_q <= 8'h00;
            holdCnt_q <= '0;
            cursorX_q <= 10'(X_CENTER);
            cursorY_q <= 10'(Y_CENTER);
            cursorS_q <= 10'(SIZE_INIT);
            penDown_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prevKey_q <= cursorBus.keycode;
            holdCnt_q <= holdCnt_d;
            cursorX_q <= cursorX_d;
            cursorY_q <= cursorY_d;
            cursorS_q <= cursorS_d;
            penDown_q <= penDown_d;
        end
    end

    // Next-state logic. The step and direction seen at an edge are applied to
    // the position at that same edge, so motion starts on the first frame of
    // a press and stops on the first frame of release.
    always_comb begin
        state_d   = state_q;
        holdCnt_d = '0;
        stepInt   = STEP;
        step      = '0;
        dx        = '0;
        dy        = '0;
        cursorS_d = cursorS_q;
        penDown_d = penDown_q;

        isDir = (cursorBus.keycode == KEY_UP)   || (cursorBus.keycode == KEY_LEFT) ||
                (cursorBus.keycode == KEY_DOWN) || (cursorBus.keycode == KEY_RIGHT);

        case (state_q)
            IDLE:    if (isDir)  state_d = MOVE;
            MOVE:    if (!isDir) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // holdCnt_d equals (k-1) for the k-th consecutive frame of a press:
        // a new or changed direction key starts again from zero.
        if (isDir && (cursorBus.keycode == prevKey_q)) begin
            if (int'(holdCnt_q) < HOLD_MAX)
                holdCnt_d = holdCnt_q + HOLD_W'(1);
            else
                holdCnt_d = holdCnt_q;
        end

        stepInt = STEP + int'(holdCnt_d) / ACCEL_FRAMES;
        if (stepInt > STEP_MAX)
            stepInt = STEP_MAX;
        step = 11'(stepInt);

        case (cursorBus.keycode)
            KEY_RIGHT: dx = step;
            KEY_LEFT:  dx = -step;
            KEY_DOWN:  dy = step;
            KEY_UP:    dy = -step;
            default:   ;
        endcase

        // Size and pen keys act only on the frame the key first appears.
        sizeUp   = (cursorBus.keycode == KEY_PLUS)  && (prevKey_q != KEY_PLUS);
        sizeDown = (cursorBus.keycode == KEY_MINUS) && (prevKey_q != KEY_MINUS);

        if (sizeUp && (cursorS_q < 10'(SIZE_MAX)))
            cursorS_d = cursorS_q + 10'd1;
        else if (sizeDown && (cursorS_q > 10'(SIZE_MIN)))
            cursorS_d = cursorS_q - 10'd1;

        if ((cursorBus.keycode == KEY_SPACE) && (prevKey_q != KEY_SPACE))
            penDown_d = ~penDown_q;

        posX    = signed'({1'b0, cursorX_q});
        posY    = signed'({1'b0, cursorY_q});
        sizeCur = signed'({1'b0, cursorS_q});
        sizeNew = signed'({1'b0, cursorS_d});

        // A move and a size change never share a frame, so the non-move path
        // re-clamps against the (possibly new) size; it is a no-op otherwise.
        if (isDir) begin
            nextX = limitMove(posX + dx, sizeCur, XMAX_S - sizeCur);
            nextY = limitMove(posY + dy, sizeCur, YMAX_S - sizeCur);
        end else begin
            nextX = clampPos(posX, sizeNew, XMAX_S - sizeNew);
            nextY = clampPos(posY, sizeNew, YMAX_S - sizeNew);
        end

        cursorX_d = 10'(nextX);
        cursorY_d = 10'(nextY);
    end

    assign cursorBus.CursorX = cursorX_q;
    assign cursorBus.CursorY = cursorY_q;
    assign cursorBus.CursorS = cursorS_q;
    assign cursorBus.Moving  = (state_q == MOVE);
    assign cursorBus.PenDown = penDown_q;

endmodule

// File: tb/tb_paint_cursor.sv
// tb_paint_cursor
// ---------------
// Directed bench for paint_cursor. Each frame's keycode is driven together
// with the expected outputs, which are pushed to a queue and compared one
// edge later against the cursor outputs.
module tb_paint_cursor;

    logic Reset;
    logic frame_clk;

    paint_cursor_if bus ();

    paint_cursor dut (
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .cursorBus (bus)
    );

    // Ten time units per frame.
    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int x;
        int y;
        int s;
        bit mov;
        bit pen;
    } expect_t;

    expect_t expQ[$];

    int total = 0;
    int bad   = 0;

    // Reference state derived from the key sequence alone.
    int         mX, mY, mS, mK;
    bit         mPen;
    logic [7:0] mPrev;

    int rightExp[10] = '{321, 322, 323, 324, 325, 326, 327, 328, 330, 332};

    // One comparison; the 11-bit compare keeps X/Z visible to ===.
    task automatic checkField(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int stepFor(input int k);
        int s;
        s = 1 + (k - 1) / 8;
        return (s > 8) ? 8 : s;
    endfunction

    function automatic int clampI(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int boundMove(input int v, input int lo, input int hi);
`ifdef CURSOR_WRAP_EN
        if (v < lo) return hi;
        if (v > hi) return lo;
        return v;
`else
        return clampI(v, lo, hi);
`endif
    endfunction

    task automatic modelReset();
        mX    = 320;
        mY    = 240;
        mS    = 4;
        mK    = 0;
        mPen  = 1'b0;
        mPrev = 8'h00;
    endtask

    // Pops the oldest expectation and compares it with the current outputs.
    task automatic checkOutput(input string tag);
        expect_t e;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: observed=empty-queue expected=entry", tag);
        end else begin
            e = expQ.pop_front();
            checkField({tag, ".x"},   {1'b0, bus.CursorX}, 11'(e.x));
            checkField({tag, ".y"},   {1'b0, bus.CursorY}, 11'(e.y));
            checkField({tag, ".s"},   {1'b0, bus.CursorS}, 11'(e.s));
            checkField({tag, ".mov"}, {10'd0, bus.Moving},  {10'd0, e.mov});
            checkField({tag, ".pen"}, {10'd0, bus.PenDown}, {10'd0, e.pen});
        end
    endtask

    // Drive one frame's keycode, queue what it should produce, then check it
    // one edge later.
    task automatic applyStimulus(input logic [7:0] key, input string tag);
        expect_t e;
        bit      dir;
        int      st;
        dir = (key == 8'h1A) || (key == 8'h04) || (key == 8'h16) || (key == 8'h07);
        if (dir) begin
            mK = (key == mPrev) ? mK + 1 : 1;
            st = stepFor(mK);
            case (key)
                8'h07: mX = boundMove(mX + st, mS, 639 - mS);
                8'h04: mX = boundMove(mX - st, mS, 639 - mS);
                8'h16: mY = boundMove(mY + st, mS, 479 - mS);
                default: mY = boundMove(mY - st, mS, 479 - mS);
            endcase
        end else begin
            mK = 0;
            if (key == 8'h2E && mPrev != 8'h2E && mS < 16) mS = mS + 1;
            if (key == 8'h2D && mPrev != 8'h2D && mS > 1)  mS = mS - 1;
            mX = clampI(mX, mS, 639 - mS);
            mY = clampI(mY, mS, 479 - mS);
        end
        if (key == 8'h2C && mPrev != 8'h2C) mPen = ~mPen;
        mPrev = key;
        e.x = mX; e.y = mY; e.s = mS; e.mov = dir; e.pen = mPen;
        expQ.push_back(e);
        bus.keycode = key;
        @(posedge frame_clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkResetValues(input string tag);
        checkField({tag, ".x"},   {1'b0, bus.CursorX}, 11'd320);
        checkField({tag, ".y"},   {1'b0, bus.CursorY}, 11'd240);
        checkField({tag, ".s"},   {1'b0, bus.CursorS}, 11'd4);
        checkField({tag, ".mov"}, {10'd0, bus.Moving},  11'd0);
        checkField({tag, ".pen"}, {10'd0, bus.PenDown}, 11'd0);
    endtask

    initial begin
        // Reset held with a direction key active: nothing may move.
        Reset       = 1'b1;
        bus.keycode = 8'h07;
        modelReset();
        repeat (3) begin
            @(posedge frame_clk);
            #1;
            checkResetValues("reset_hold");
        end
        Reset = 1'b0;
        applyStimulus(8'h00, "idle");

        // Right for 10 frames: step becomes 2 on the ninth frame.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'h07, "right");
            checkField("right_table", {1'b0, bus.CursorX}, 11'(rightExp[i]));
        end
        applyStimulus(8'h00, "right_release");
        checkField("right_release_x", {1'b0, bus.CursorX}, 11'd332);

        // Down then straight to up: the direction change restarts the step.
        repeat (3) applyStimulus(8'h16, "down");
        repeat (3) applyStimulus(8'h1A, "up");
        checkField("up_back_y", {1'b0, bus.CursorY}, 11'd240);
        applyStimulus(8'h00, "ud_release");

        // Long left hold: step reaches 8 at frame 57 and stays there.
        for (int i = 1; i <= 400; i++) begin
            applyStimulus(8'h04, "left");
`ifndef CURSOR_WRAP_EN
            if (i == 57) checkField("left_f57_x", {1'b0, bus.CursorX}, 11'd100);
            if (i == 65) checkField("left_f65_x", {1'b0, bus.CursorX}, 11'd36);
`endif
        end
`ifndef CURSOR_WRAP_EN
        checkField("left_sat_x", {1'b0, bus.CursorX}, 11'd4);
`endif
        applyStimulus(8'h00, "left_release");

        // Park at X=5 with size 4, then cross the left limit.
        applyStimulus(8'h2E, "park_up");
        applyStimulus(8'h00, "park_rel");
        applyStimulus(8'h2D, "park_dn");
        applyStimulus(8'h00, "park_rel");
        applyStimulus(8'h04, "edge_1");
`ifndef CURSOR_WRAP_EN
        checkField("edge_1_x", {1'b0, bus.CursorX}, 11'd4);
`endif
        applyStimulus(8'h04, "edge_2");
`ifndef CURSOR_WRAP_EN
        checkField("edge_2_x", {1'b0, bus.CursorX}, 11'd4);
`endif
        applyStimulus(8'h00, "edge_release");

        // Holding '=' changes the size once only.
        repeat (20) applyStimulus(8'h2E, "size_hold");
        checkField("size_hold_s", {1'b0, bus.CursorS}, 11'd5);
        applyStimulus(8'h00, "size_release");
        repeat (15) begin
            applyStimulus(8'h2E, "size_up");
            applyStimulus(8'h00, "size_up_rel");
        end
        checkField("size_max_s", {1'b0, bus.CursorS}, 11'd16);

        // Back to size 4, run to the right edge, then grow the brush there.
        repeat (12) begin
            applyStimulus(8'h2D, "size_dn");
            applyStimulus(8'h00, "size_dn_rel");
        end
        repeat (150) applyStimulus(8'h07, "right_run");
`ifndef CURSOR_WRAP_EN
        checkField("right_sat_x", {1'b0, bus.CursorX}, 11'd635);
`endif
        applyStimulus(8'h00, "right_run_rel");
        repeat (15) begin
            applyStimulus(8'h2E, "reclamp_up");
            applyStimulus(8'h00, "reclamp_rel");
        end
`ifndef CURSOR_WRAP_EN
        checkField("reclamp_x", {1'b0, bus.CursorX}, 11'd623);
`endif
        checkField("reclamp_s", {1'b0, bus.CursorS}, 11'd16);
        repeat (20) begin
            applyStimulus(8'h2D, "size_min");
            applyStimulus(8'h00, "size_min_rel");
        end
        checkField("size_min_s", {1'b0, bus.CursorS}, 11'd1);

        // Pen toggles on the first frame of space only.
        repeat (5) applyStimulus(8'h2C, "pen_hold");
        checkField("pen_hold", {10'd0, bus.PenDown}, 11'd1);
        applyStimulus(8'h00, "pen_rel");
        applyStimulus(8'h2C, "pen_again");
        checkField("pen_again", {10'd0, bus.PenDown}, 11'd0);
        applyStimulus(8'h00, "pen_rel2");

        // Asynchronous reset mid-acceleration with the pen down.
        applyStimulus(8'h2C, "pen_on");
        applyStimulus(8'h00, "pen_on_rel");
        repeat (12) applyStimulus(8'h07, "accel");
        #2;
        Reset = 1'b1;
        #1;
        checkResetValues("async_reset");
        @(posedge frame_clk);
        #1;
        checkResetValues("async_reset_edge");
        Reset = 1'b0;
        modelReset();
        applyStimulus(8'h07, "post_reset");
        checkField("post_reset_x", {1'b0, bus.CursorX}, 11'd321);
        applyStimulus(8'h00, "final_release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
